// File: rtl/audio_pkg.sv
// Shared constants and sample/level helpers for the audio level meter.
package audio_pkg;

  localparam int SMP_W = 16;
  localparam int LV_W  = 10;
  localparam int ABS_W = SMP_W - 1;

  localparam logic [LV_W-1:0] LV_ZERO = 10'd512;
  localparam logic [LV_W-1:0] LV_FULL = 10'd1023;

  // Magnitude of a two's complement sample; -32768 saturates to 32767.
  function automatic logic [ABS_W-1:0] absSat(input logic [SMP_W-1:0] smp);
    logic [SMP_W-1:0] negVal;
    negVal = ~smp + 16'd1;
    if (smp == 16'h8000)
      return 15'h7FFF;
    else if (smp[SMP_W-1])
      return negVal[ABS_W-1:0];
    else
      return smp[ABS_W-1:0];
  endfunction

  function automatic logic isClip(input logic [SMP_W-1:0] smp);
    return (smp == 16'h7FFF) || (smp == 16'h8000);
  endfunction

  function automatic logic [LV_W-1:0] toLevel(input logic [ABS_W-1:0] mag);
    logic [LV_W-1:0] lv;
    lv = LV_ZERO + {1'b0, mag[ABS_W-1:6]};
    return (lv > LV_FULL) ? LV_FULL : lv;
  endfunction

endpackage

// File: rtl/audio_level_ch.sv
// One channel of the level meter: magnitude, per-window running max and
// clip indicator with a hold measured in windows.
module audio_level_ch
  import audio_pkg::*;
#(
  parameter int CLIP_HOLD = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_winEnd,
  input  logic [SMP_W-1:0] i_smp,
  output logic [LV_W-1:0]  o_level,
  output logic             o_clip
);

  localparam logic [7:0] HOLD_LOAD = 8'(CLIP_HOLD);

  logic [ABS_W-1:0] smpAbs;
  logic [ABS_W-1:0] runMax;
  logic [ABS_W-1:0] maxWithSmp;
  logic             smpClip;
  logic             clipSeen;
  logic [7:0]       holdCnt;
  logic [7:0]       holdNext;

  always_comb begin
    smpAbs     = absSat(i_smp);
    smpClip    = isClip(i_smp);
    maxWithSmp = (smpAbs > runMax) ? smpAbs : runMax;
    holdNext   = holdCnt;
    if (i_valid) begin
      // A clip anywhere in the closing window wins over the decrement.
      if (i_winEnd) begin
        if (smpClip || clipSeen)
          holdNext = HOLD_LOAD;
        else if (holdCnt != 8'd0)
          holdNext = holdCnt - 8'd1;
      end else if (smpClip) begin
        holdNext = HOLD_LOAD;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      runMax   <= '0;
      clipSeen <= 1'b0;
      holdCnt  <= 8'd0;
      o_level  <= LV_ZERO;
      o_clip   <= 1'b0;
    end else begin
      if (i_valid) begin
        if (i_winEnd) begin
          o_level  <= toLevel(maxWithSmp);
          runMax   <= '0;
          clipSeen <= 1'b0;
        end else begin
          runMax   <= maxWithSmp;
          clipSeen <= clipSeen | smpClip;
        end
      end
      holdCnt <= holdNext;
      o_clip  <= (holdNext != 8'd0);
    end
  end

endmodule

// File: rtl/audio_level_meter.sv
// Stereo audio level meter: shared window counter plus two identical
// channel slices; levels refresh once per window of accepted pairs.
module audio_level_meter
  import audio_pkg::*;
#(
  parameter int WINDOW_SAMPLES = 1024,
  parameter int CLIP_HOLD      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_smp_valid,
  input  logic [SMP_W-1:0] i_smp_L,
  input  logic [SMP_W-1:0] i_smp_R,
  output logic [LV_W-1:0]  o_audioLv_L,
  output logic [LV_W-1:0]  o_audioLv_R,
  output logic             o_lv_valid,
  output logic             o_clip_L,
  output logic             o_clip_R
);

  localparam logic [15:0] WIN_LAST = 16'(WINDOW_SAMPLES - 1);

  logic [15:0] winCnt;
  logic        winEnd;

  assign winEnd = i_smp_valid && (winCnt == WIN_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      winCnt     <= 16'd0;
      o_lv_valid <= 1'b0;
    end else begin
      if (i_smp_valid)
        winCnt <= winEnd ? 16'd0 : winCnt + 16'd1;
      o_lv_valid <= winEnd;
    end
  end

  audio_level_ch #(.CLIP_HOLD(CLIP_HOLD)) u_chL (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_smp_valid),
    .i_winEnd (winEnd),
    .i_smp    (i_smp_L),
    .o_level  (o_audioLv_L),
    .o_clip   (o_clip_L)
  );

  audio_level_ch #(.CLIP_HOLD(CLIP_HOLD)) u_chR (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_smp_valid),
    .i_winEnd (winEnd),
    .i_smp    (i_smp_R),
    .o_level  (o_audioLv_R),
    .o_clip   (o_clip_R)
  );

endmodule

// File: tb/tb_audio_level_meter.sv
// Randomised and directed check of audio_level_meter against a window-level
// reference model (WINDOW_SAMPLES=4, CLIP_HOLD=2).
module tb_audio_level_meter;

  localparam int W = 4;
  localparam int H = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_smp_valid;
  logic [15:0] i_smp_L;
  logic [15:0] i_smp_R;
  logic [9:0]  o_audioLv_L;
  logic [9:0]  o_audioLv_R;
  logic        o_lv_valid;
  logic        o_clip_L;
  logic        o_clip_R;

  audio_level_meter #(.WINDOW_SAMPLES(W), .CLIP_HOLD(H)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_smp_valid (i_smp_valid),
    .i_smp_L     (i_smp_L),
    .i_smp_R     (i_smp_R),
    .o_audioLv_L (o_audioLv_L),
    .o_audioLv_R (o_audioLv_R),
    .o_lv_valid  (o_lv_valid),
    .o_clip_L    (o_clip_L),
    .o_clip_R    (o_clip_R)
  );

  always #10 i_clk = ~i_clk;

  int nAsserts = 0;
  int nFails   = 0;

  task automatic checkEq(input string tag, input int obs, input int exp);
    nAsserts++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: samples of the open window are kept as magnitudes,
  // clips are remembered by the index of the window they fell into.
  int qL[$];
  int qR[$];
  int expLvL, expLvR;
  int expValid;
  int winDone;
  int lastClipL, lastClipR;

  function automatic int absOf(input int s);
    if (s == -32768) return 32767;
    return (s < 0) ? -s : s;
  endfunction

  function automatic int clipActive(input int lastClip, input int done);
    return (lastClip >= 0 && done <= lastClip + H) ? 1 : 0;
  endfunction

  task automatic modelReset();
    qL.delete();
    qR.delete();
    expLvL = 512;
    expLvR = 512;
    expValid = 0;
    winDone = 0;
    lastClipL = -1;
    lastClipR = -1;
  endtask

  task automatic modelAccept(input int l, input int r);
    int mL, mR;
    qL.push_back(absOf(l));
    qR.push_back(absOf(r));
    if (l == 32767 || l == -32768) lastClipL = winDone;
    if (r == 32767 || r == -32768) lastClipR = winDone;
    if (qL.size() == W) begin
      mL = 0;
      mR = 0;
      foreach (qL[i]) if (qL[i] > mL) mL = qL[i];
      foreach (qR[i]) if (qR[i] > mR) mR = qR[i];
      expLvL = 512 + mL / 64;
      expLvR = 512 + mR / 64;
      expValid = 1;
      winDone++;
      qL.delete();
      qR.delete();
      $display("window %0d: expected levels L=%0d R=%0d, observed L=%0d R=%0d",
               winDone, expLvL, expLvR, o_audioLv_L, o_audioLv_R);
    end
  endtask

  task automatic checkOutputs(input string tag);
    checkEq({tag, ".lvL"},   int'(o_audioLv_L), expLvL);
    checkEq({tag, ".lvR"},   int'(o_audioLv_R), expLvR);
    checkEq({tag, ".valid"}, int'(o_lv_valid),  expValid);
    checkEq({tag, ".clipL"}, int'(o_clip_L),    clipActive(lastClipL, winDone));
    checkEq({tag, ".clipR"}, int'(o_clip_R),    clipActive(lastClipR, winDone));
  endtask

  // Starts and ends on a falling edge; one rising edge in between.
  task automatic cyc(input string tag, input bit v, input int l, input int r);
    i_smp_valid = v;
    i_smp_L = 16'(l);
    i_smp_R = 16'(r);
    @(negedge i_clk);
    expValid = 0;
    if (v) modelAccept(l, r);
    checkOutputs(tag);
  endtask

  task automatic doReset();
    i_smp_valid = 1'b0;
    #3 i_rst_n = 1'b0;
    #1;
    modelReset();
    checkOutputs("rst.async");
    @(negedge i_clk);
    @(negedge i_clk);
    checkOutputs("rst.hold");
    i_rst_n = 1'b1;
  endtask

  function automatic int randSample();
    case ($urandom_range(0, 7))
      0: return 32767;
      1: return -32768;
      2: return int'($urandom_range(0, 200)) - 100;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  initial begin
    i_rst_n = 1'b0;
    i_smp_valid = 1'b0;
    i_smp_L = 16'd0;
    i_smp_R = 16'd0;
    modelReset();
    @(negedge i_clk);
    @(negedge i_clk);
    doReset();

    // Idle after reset: nothing moves.
    for (int i = 0; i < 10; i++) cyc("idle", 1'b0, 0, 0);

    // Basic window: max magnitude 6400 -> 612.
    cyc("win", 1'b1, 100, 0);
    cyc("win", 1'b1, -6400, 0);
    cyc("win", 1'b1, 64, 0);
    cyc("win", 1'b1, 0, 0);
    cyc("win.after", 1'b0, 0, 0);

    // Clip in window 1, then three quiet windows.
    doReset();
    cyc("clip", 1'b1, -32768, 0);
    for (int i = 0; i < 3; i++) cyc("clip", 1'b1, 0, 0);
    for (int i = 0; i < 12; i++) cyc("clip.quiet", 1'b1, 0, 0);

    // Loud window then quieter window: no decay.
    for (int i = 0; i < 4; i++) cyc("loud", 1'b1, 6400, 0);
    for (int i = 0; i < 4; i++) cyc("quiet", 1'b1, 640, 0);

    // Sparse strobes; idle cycles carry full-scale data that must be ignored.
    cyc("sparse", 1'b1, 300, -300);
    cyc("sparse", 1'b1, 400, -500);
    for (int i = 0; i < 2; i++) cyc("sparse.gap", 1'b0, 32767, 32767);
    cyc("sparse", 1'b1, 100, 100);
    for (int i = 0; i < 6; i++) cyc("sparse.gap", 1'b0, 32767, 32767);
    cyc("sparse", 1'b1, 200, 200);
    cyc("sparse.after", 1'b0, 32767, 32767);

    // Clip on the last pair of a window, right channel.
    for (int i = 0; i < 3; i++) cyc("lastclip", 1'b1, 10, 10);
    cyc("lastclip", 1'b1, 10, 32767);
    for (int i = 0; i < 12; i++) cyc("lastclip.quiet", 1'b1, 0, 0);

    // Reset mid-window discards the partial window.
    cyc("partial", 1'b1, 20000, 20000);
    cyc("partial", 1'b1, 20000, 20000);
    doReset();
    for (int i = 0; i < 4; i++) cyc("postrst", 1'b1, 1280, 0);
    cyc("postrst.after", 1'b0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      cyc("rand", ($urandom_range(0, 1) == 1), randSample(), randSample());

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
